// File: rtl/che_map_sched.sv
// che_map_sched: CLAHE CDF-map pixel scheduler issuing quadrant valids, tile indices and blend weights.
// Optional `CHE_MAP_SCHED_ERR_EN adds a sticky err_o for mid-frame aborts and pixels offered while idle.
`ifndef DAT_PIX_WD
`define DAT_PIX_WD 8
`endif
module che_map_sched #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int TILE_W  = 80,
    parameter int TILE_H  = 60,
    parameter int CNT_WD  = 10,
    parameter int TIDX_WD = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   frm_start_i,
    input  logic                   hist_rdy_i,
    input  logic                   pix_vld_i,
    output logic                   pix_rdy_o,
    input  logic [`DAT_PIX_WD-1:0] dat_pix_i,
    output logic [`DAT_PIX_WD-1:0] dat_pix_o,
    output logic                   ul_vld_o,
    output logic                   ur_vld_o,
    output logic                   bl_vld_o,
    output logic                   br_vld_o,
    output logic [TIDX_WD-1:0]     tile_x_o,
    output logic [TIDX_WD-1:0]     tile_y_o,
    output logic [CNT_WD-1:0]      wgt_x_o,
    output logic [CNT_WD-1:0]      wgt_y_o,
    output logic                   frm_done_o
`ifdef CHE_MAP_SCHED_ERR_EN
    ,output logic                  err_o
`endif
);
    localparam logic [CNT_WD-1:0] HW  = CNT_WD'(TILE_W / 2);
    localparam logic [CNT_WD-1:0] HH  = CNT_WD'(TILE_H / 2);
    localparam logic [CNT_WD-1:0] XL  = CNT_WD'(IMG_W - 1);
    localparam logic [CNT_WD-1:0] YL  = CNT_WD'(IMG_H - 1);
    localparam logic [CNT_WD-1:0] TWL = CNT_WD'(TILE_W - 1);
    localparam logic [CNT_WD-1:0] THL = CNT_WD'(TILE_H - 1);
    localparam logic [CNT_WD-1:0] XR  = CNT_WD'(IMG_W - TILE_W / 2);
    localparam logic [CNT_WD-1:0] YB  = CNT_WD'(IMG_H - TILE_H / 2);

    typedef enum logic [1:0] {IDLE, WAIT_HIST, RUN, DONE} state_t;
    state_t st, st_nx;
    logic [CNT_WD-1:0]  x, y, ox, oy;
    logic [TIDX_WD-1:0] tx, ty;
    logic acc, iss, lx, ly, lcol, rcol, trow, brow;

    assign pix_rdy_o = st == RUN;
    assign acc  = pix_vld_i & pix_rdy_o;
    // an accept coinciding with an abort belongs to the discarded frame
    assign iss  = acc & ~frm_start_i;
    assign lx   = x == XL;
    assign ly   = y == YL;
    assign lcol = x >= HW;
    assign rcol = x < XR;
    assign trow = y >= HH;
    assign brow = y < YB;

    always_comb begin
        st_nx = st;
        if (frm_start_i) st_nx = WAIT_HIST;
        else if (st == WAIT_HIST && hist_rdy_i) st_nx = RUN;
        else if (iss && lx && ly) st_nx = DONE;
        else if (st == DONE) st_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st <= IDLE;
        else st <= st_nx;
    end

    // the first offset wrap of a line/frame lies inside tile 0, so it does not advance the tile index
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || frm_start_i) begin
            x  <= '0;
            y  <= '0;
            ox <= HW;
            oy <= HH;
            tx <= '0;
            ty <= '0;
        end else if (iss) begin
            x  <= lx ? '0 : x + CNT_WD'(1);
            ox <= lx ? HW : (ox == TWL ? '0 : ox + CNT_WD'(1));
            tx <= lx ? '0 : ((ox == TWL && lcol) ? tx + TIDX_WD'(1) : tx);
            if (lx) begin
                y  <= ly ? '0 : y + CNT_WD'(1);
                oy <= ly ? HH : (oy == THL ? '0 : oy + CNT_WD'(1));
                ty <= ly ? '0 : ((oy == THL && trow) ? ty + TIDX_WD'(1) : ty);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ul_vld_o   <= 1'b0;
            ur_vld_o   <= 1'b0;
            bl_vld_o   <= 1'b0;
            br_vld_o   <= 1'b0;
            frm_done_o <= 1'b0;
            dat_pix_o  <= '0;
            tile_x_o   <= '0;
            tile_y_o   <= '0;
            wgt_x_o    <= '0;
            wgt_y_o    <= '0;
        end else begin
            ul_vld_o   <= iss & trow & lcol;
            ur_vld_o   <= iss & trow & rcol;
            bl_vld_o   <= iss & brow & lcol;
            br_vld_o   <= iss & brow & rcol;
            frm_done_o <= st == DONE && !frm_start_i;
            if (iss) begin
                dat_pix_o <= dat_pix_i;
                tile_x_o  <= tx;
                tile_y_o  <= ty;
                wgt_x_o   <= ox;
                wgt_y_o   <= oy;
            end
        end
    end

`ifdef CHE_MAP_SCHED_ERR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_o <= 1'b0;
        else if ((frm_start_i && st == RUN) || (pix_vld_i && st == IDLE)) err_o <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_che_map_sched.sv
// tb_che_map_sched: directed bench for che_map_sched on a 16x8 frame with 8x4 tiles.
`ifndef DAT_PIX_WD
`define DAT_PIX_WD 8
`endif
module tb_che_map_sched;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic frm_start_i = 1'b0, hist_rdy_i = 1'b0, pix_vld_i = 1'b0;
    logic [`DAT_PIX_WD-1:0] dat_pix_i = '0;
    logic pix_rdy_o, ul_vld_o, ur_vld_o, bl_vld_o, br_vld_o, frm_done_o;
    logic [`DAT_PIX_WD-1:0] dat_pix_o;
    logic [1:0] tile_x_o, tile_y_o;
    logic [4:0] wgt_x_o, wgt_y_o;
`ifdef CHE_MAP_SCHED_ERR_EN
    logic err_o;
`endif

    che_map_sched #(.IMG_W(16), .IMG_H(8), .TILE_W(8), .TILE_H(4), .CNT_WD(5), .TIDX_WD(2)) dut (
        .clk(clk), .rstn(rstn), .frm_start_i(frm_start_i), .hist_rdy_i(hist_rdy_i),
        .pix_vld_i(pix_vld_i), .pix_rdy_o(pix_rdy_o), .dat_pix_i(dat_pix_i), .dat_pix_o(dat_pix_o),
        .ul_vld_o(ul_vld_o), .ur_vld_o(ur_vld_o), .bl_vld_o(bl_vld_o), .br_vld_o(br_vld_o),
        .tile_x_o(tile_x_o), .tile_y_o(tile_y_o), .wgt_x_o(wgt_x_o), .wgt_y_o(wgt_y_o),
        .frm_done_o(frm_done_o)
`ifdef CHE_MAP_SCHED_ERR_EN
        , .err_o(err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int v; int tx; int ty; int wx; int wy;} pt_t;
    // hand-worked pixels: v = {ul,ur,bl,br}
    pt_t pts[5] = '{
        '{0, 0, 4'b0001, 0, 0, 4, 2},
        '{4, 2, 4'b1111, 0, 0, 0, 0},
        '{15, 7, 4'b1000, 1, 1, 3, 1},
        '{11, 1, 4'b0011, 0, 0, 7, 3},
        '{12, 1, 4'b0010, 1, 0, 0, 3}
    };

    int checks = 0, failures = 0;
    int mx = 0, my = 0, n_acc = 0, done_cnt = 0;
    bit done_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit vld, input bit fs, input bit hr);
        bit acc;
        @(negedge clk);
        pix_vld_i   = vld;
        frm_start_i = fs;
        hist_rdy_i  = hr;
        dat_pix_i   = 8'((my * 16 + mx) ^ 'h5A);
        acc = vld && pix_rdy_o && !fs;
        @(posedge clk);
        #1;
        chk("ul_vld", 32'(ul_vld_o), 32'(acc && my >= 2 && mx >= 4));
        chk("ur_vld", 32'(ur_vld_o), 32'(acc && my >= 2 && mx < 12));
        chk("bl_vld", 32'(bl_vld_o), 32'(acc && my < 6 && mx >= 4));
        chk("br_vld", 32'(br_vld_o), 32'(acc && my < 6 && mx < 12));
        chk("frm_done", 32'(frm_done_o), 32'(done_exp));
        done_cnt += int'(frm_done_o);
        if (acc) begin
            chk("tile_x", 32'(tile_x_o), mx < 4 ? 0 : (mx - 4) / 8);
            chk("tile_y", 32'(tile_y_o), my < 2 ? 0 : (my - 2) / 4);
            chk("wgt_x", 32'(wgt_x_o), mx < 4 ? mx + 4 : (mx - 4) % 8);
            chk("wgt_y", 32'(wgt_y_o), my < 2 ? my + 2 : (my - 2) % 4);
            chk("dat", 32'(dat_pix_o), (my * 16 + mx) ^ 'h5A);
            foreach (pts[i]) if (pts[i].x == mx && pts[i].y == my) begin
                chk("hand_vld", 32'({ul_vld_o, ur_vld_o, bl_vld_o, br_vld_o}), pts[i].v);
                chk("hand_tile", 32'({tile_x_o, tile_y_o}), pts[i].tx * 4 + pts[i].ty);
                chk("hand_wgt", 32'({wgt_x_o, wgt_y_o}), pts[i].wx * 32 + pts[i].wy);
            end
        end
        done_exp = acc && mx == 15 && my == 7;
        n_acc += int'(acc);
        if (fs) begin
            mx = 0;
            my = 0;
        end else if (acc) begin
            mx = (mx + 1) % 16;
            if (mx == 0) my = (my + 1) % 8;
        end
    endtask

    task automatic stream(input int n, input int gap_pct);
        int start = n_acc;
        int cnt = 0;
        while (n_acc - start < n && cnt < 2000) begin
            cyc($urandom_range(0, 99) >= gap_pct, 1'b0, 1'b0);
            cnt++;
        end
        chk("stream_cnt", n_acc - start, n);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(pix_rdy_o), 0);
        chk("rst_vld", 32'({ul_vld_o, ur_vld_o, bl_vld_o, br_vld_o}), 0);
        chk("rst_done", 32'(frm_done_o), 0);
        chk("rst_dat", 32'(dat_pix_o), 0);
        chk("rst_tile", 32'({tile_x_o, tile_y_o}), 0);
        chk("rst_wgt", 32'({wgt_x_o, wgt_y_o}), 0);
`ifdef CHE_MAP_SCHED_ERR_EN
        chk("rst_err", 32'(err_o), 0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        // full-rate frame; hist_rdy drops once running
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        stream(128, 0);
        cyc(0, 0, 0);
        chk("idle_rdy", 32'(pix_rdy_o), 0);
        cyc(0, 0, 0);
        // pixel held valid while histograms are not ready
        cyc(1, 1, 0);
        repeat (5) begin
            cyc(1, 0, 0);
            chk("wait_rdy", 32'(pix_rdy_o), 0);
        end
        cyc(1, 0, 1);
        chk("run_rdy", 32'(pix_rdy_o), 1);
        stream(128, 0);
        cyc(0, 0, 0);
        // abort after px 40, then a gappy restart
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        stream(41, 0);
        cyc(0, 1, 0);
        chk("abort_rdy", 32'(pix_rdy_o), 0);
        cyc(0, 0, 1);
        stream(128, 30);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("ndone", done_cnt, 3);
`ifdef CHE_MAP_SCHED_ERR_EN
        chk("err", 32'(err_o), 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
